// File: rtl/mole_game_ctrl.sv
// mole_game_ctrl: round timer, pseudo-random mole spawner/expiry and hit scorer; define MOLE_MISS_PENALTY_EN to penalise hits on empty holes
module mole_game_ctrl #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MOLE_LIFE  = 3,
  parameter int SPAWN_GAP  = 2,
  parameter int GAME_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit_valid,
  input  logic [3:0] hit_idx,
  output logic [8:0] map,
  output logic [3:0] score,
  output logic       playing,
  output logic       game_over
);
  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;
  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      rem_q, rem_d;
  logic [3:0]      spawn_q, spawn_d;
  logic [8:0][3:0] life_q, life_d;
  logic [8:0]      map_q, map_d;
  logic [3:0]      score_q, score_d;
  logic            playing_q, playing_d;
  logic            over_q, over_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            tick, last_tick, spawn_now, hit_ok;
  logic [3:0]      cand;
  // Round control: tick divider, remaining ticks, spawn cadence and FSM
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rem_d     = rem_q;
    spawn_d   = spawn_q;
    lfsr_d    = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    tick      = (state_q == S_PLAY) && (div_q == DW'(TICK_DIV - 1));
    last_tick = tick && (rem_q == 8'd1);
    spawn_now = tick && (spawn_q == 4'd1);
    cand      = (lfsr_q[3:0] >= 4'd9) ? lfsr_q[3:0] - 4'd9 : lfsr_q[3:0];
    hit_ok    = (state_q == S_PLAY) && hit_valid && (hit_idx <= 4'd8);
    if (state_q != S_PLAY) begin
      if (start) begin
        state_d = S_PLAY;
        div_d   = '0;
        rem_d   = 8'(GAME_TICKS);
        spawn_d = 4'(SPAWN_GAP);
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        rem_d   = rem_q - 8'd1;
        spawn_d = spawn_now ? 4'(SPAWN_GAP) : spawn_q - 4'd1;
      end
      if (last_tick) state_d = S_OVER;
    end
    playing_d = (state_d == S_PLAY);
    over_d    = (state_d == S_OVER);
  end
  // Hole board: expiry, spawn (judged on the pre-update map), hits and score
  always_comb begin
    map_d   = map_q;
    life_d  = life_q;
    score_d = score_q;
    if (state_q != S_PLAY) begin
      if (start) begin
        map_d   = '0;
        life_d  = '0;
        score_d = '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (tick && map_q[i]) begin
          life_d[i] = life_q[i] - 4'd1;
          if (life_q[i] == 4'd1) map_d[i] = 1'b0;
        end
      end
      if (spawn_now && !map_q[cand]) begin
        map_d[cand]  = 1'b1;
        life_d[cand] = 4'(MOLE_LIFE);
      end
      if (hit_ok && map_q[hit_idx]) begin
        map_d[hit_idx]  = 1'b0;
        life_d[hit_idx] = '0;
        score_d         = (score_q == 4'd15) ? score_q : score_q + 4'd1;
      end
`ifdef MOLE_MISS_PENALTY_EN
      else if (hit_ok && score_q != 4'd0) begin
        score_d = score_q - 4'd1;
      end
`endif
      if (last_tick) map_d = '0;
    end
  end
  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      rem_q     <= '0;
      spawn_q   <= '0;
      life_q    <= '0;
      map_q     <= '0;
      score_q   <= '0;
      playing_q <= 1'b0;
      over_q    <= 1'b0;
      lfsr_q    <= 16'hACE1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rem_q     <= rem_d;
      spawn_q   <= spawn_d;
      life_q    <= life_d;
      map_q     <= map_d;
      score_q   <= score_d;
      playing_q <= playing_d;
      over_q    <= over_d;
      lfsr_q    <= lfsr_d;
    end
  end
  assign map       = map_q;
  assign score     = score_q;
  assign playing   = playing_q;
  assign game_over = over_q;
endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb_mole_game_ctrl: randomized play checked every cycle against a tick/deadline model, plus literal scenario checks
module tb_mole_game_ctrl;
  localparam int TD = 4, ML = 3, SG = 2, GT = 10;
`ifdef MOLE_MISS_PENALTY_EN
  localparam int MISS_SCORE = 0;
`else
  localparam int MISS_SCORE = 1;
`endif
  logic       clk = 0, rst = 1, start = 0, hit_valid = 0;
  logic [3:0] hit_idx = 0;
  logic [8:0] map;
  logic [3:0] score;
  logic       playing, game_over;
  int         total = 0, bad = 0, ecnt = 0;
  bit         chk_en = 0;

  mole_game_ctrl #(.TICK_DIV(TD), .MOLE_LIFE(ML), .SPAWN_GAP(SG), .GAME_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .map(map), .score(score), .playing(playing), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Model: phase (0 idle, 1 play, 2 over), cycles and ticks since start, per-hole expiry tick
  int          m_st = 0, m_cyc = 0, m_tick = 0, m_score = 0;
  int          exp_at [9];
  logic [8:0]  m_map = '0;
  logic [15:0] m_lfsr = 16'hACE1;

  always @(posedge clk or negedge rst) begin : model
    logic [8:0] nm;
    int ns, t, c;
    bit tk;
    if (!rst) begin
      m_st = 0; m_cyc = 0; m_tick = 0; m_score = 0; m_map = '0; m_lfsr = 16'hACE1;
      foreach (exp_at[i]) exp_at[i] = 0;
    end else begin
      nm = m_map;
      ns = m_score;
      if (m_st == 1) begin
        tk = (m_cyc % TD) == TD - 1;
        t  = m_tick + (tk ? 1 : 0);
        if (tk) begin
          for (int i = 0; i < 9; i++) if (m_map[i] && exp_at[i] == t) nm[i] = 1'b0;
          if (t % SG == 0) begin
            c = int'(m_lfsr[3:0]);
            if (c >= 9) c -= 9;
            if (!m_map[c]) begin nm[c] = 1'b1; exp_at[c] = t + ML; end
          end
        end
        if (hit_valid && hit_idx <= 8) begin
          if (m_map[hit_idx]) begin nm[hit_idx] = 1'b0; if (ns < 15) ns++; end
`ifdef MOLE_MISS_PENALTY_EN
          else if (ns > 0) ns--;
`endif
        end
        if (tk && t == GT) begin nm = '0; m_st = 2; end
        m_cyc++;
        m_tick = t;
      end else if (start) begin
        m_st = 1; m_cyc = 0; m_tick = 0; nm = '0; ns = 0;
      end
      m_map   = nm;
      m_score = ns;
      m_lfsr  = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("map", 32'(map), 32'(m_map));
      chk("score", 32'(score), 32'(m_score));
      chk("playing", 32'(playing), 32'(m_st == 1));
      chk("game_over", 32'(game_over), 32'(m_st == 2));
    end
  end

  task automatic to_edge(int k);
    while (ecnt < k) begin
      @(negedge clk);
      ecnt++;
    end
  endtask

  task automatic reset_start();
    @(negedge clk);
    #2 rst = 0;
    hit_valid = 0;
    start = 0;
    @(negedge clk);
    rst = 1;
    start = 1;
    ecnt = 0;
    to_edge(1);
    start = 0;
  endtask

  task automatic run_spawn();
    reset_start();
    chk("start_playing", 32'(playing), 1);
    chk("start_not_over", 32'(game_over), 0);
    chk("start_score", 32'(score), 0);
    to_edge(8);
    chk("pre_spawn_map", 32'(map), 0);
    to_edge(9);
    chk("first_spawn_hole3", 32'(map), 32'h008);
    to_edge(20);
    chk("mole_up_tick4", 32'(map[3]), 1);
    to_edge(21);
    chk("mole_expired_tick5", 32'(map[3]), 0);
    to_edge(40);
    chk("playing_tick9", 32'(playing), 1);
    to_edge(41);
    chk("round_over", 32'(game_over), 1);
    chk("round_not_playing", 32'(playing), 0);
    chk("round_map_clear", 32'(map), 0);
  endtask

  initial begin
    logic [3:0] idx;
    #1 rst = 0;
    reset_start();
    chk_en = 1;
    run_spawn();
    // hit, repeat hit, out-of-range hit, start during play
    reset_start();
    to_edge(9);
    hit_valid = 1; hit_idx = 3;
    to_edge(10);
    chk("hit_clears", 32'(map[3]), 0);
    chk("hit_scores", 32'(score), 1);
    to_edge(11);
    hit_valid = 0;
    chk("hit_empty", 32'(score), MISS_SCORE);
    hit_valid = 1; hit_idx = 12;
    to_edge(12);
    hit_valid = 0;
    chk("hit_idx12", 32'(score), MISS_SCORE);
    start = 1;
    to_edge(13);
    start = 0;
    chk("start_in_play", 32'(playing), 1);
    to_edge(40);
    chk("start_in_play_len", 32'(playing), 1);
    to_edge(41);
    chk("start_in_play_over", 32'(game_over), 1);
    chk("score_held", 32'(score), MISS_SCORE);
    // hit on the expiry tick
    reset_start();
    to_edge(20);
    hit_valid = 1; hit_idx = 3;
    to_edge(21);
    hit_valid = 0;
    chk("expiry_hit_score", 32'(score), 1);
    chk("expiry_hit_map", 32'(map[3]), 0);
    // asynchronous reset mid-round, then identical replay
    reset_start();
    to_edge(9);
    hit_valid = 1; hit_idx = 3;
    to_edge(18);
    hit_valid = 0;
    #2 rst = 0;
    #1;
    chk("async_map", 32'(map), 0);
    chk("async_score", 32'(score), 0);
    chk("async_playing", 32'(playing), 0);
    chk("async_over", 32'(game_over), 0);
    run_spawn();
    // score saturation with the board held full
    reset_start();
    chk_en = 0;
    force dut.map_q = 9'h1ff;
    hit_valid = 1; hit_idx = 0;
    to_edge(15);
    chk("sat_14", 32'(score), 14);
    to_edge(17);
    hit_valid = 0;
    to_edge(18);
    chk("sat_15", 32'(score), 15);
    release dut.map_q;
    reset_start();
    chk_en = 1;
    // randomized play
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 29) == 0);
      hit_valid = ($urandom_range(0, 2) == 0);
      if (m_map != 0 && $urandom_range(0, 1) == 1) begin
        do idx = 4'($urandom_range(0, 8)); while (!m_map[idx]);
        hit_idx = idx;
      end else begin
        hit_idx = 4'($urandom_range(0, 15));
      end
    end
    @(negedge clk);
    start = 0;
    hit_valid = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game-logic stage feeding the VGA/seven-segment display top: it owns the round timer, spawns moles pseudo-randomly into the nine holes, expires them after a fixed lifetime, and scores player hits. Its `map` and `score` outputs drive the display's `map[8:0]` and `score[3:0]` inputs directly. Player input arrives as a one-cycle hit strobe plus hole index from the keyboard/button decoder.

## Interface
- `TICK_DIV`, 100_000_000: `clk` cycles per game tick, minimum 2.
- `MOLE_LIFE`, 3: ticks a mole stays up, range 1..15.
- `SPAWN_GAP`, 2: ticks between spawn attempts, range 1..15.
- `GAME_TICKS`, 60: round length in ticks, range 1..255.

Ports:
- `clk` in 1: single system clock, 100 MHz.
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `start` in 1: one-cycle pulse that begins a round.
- `hit_valid` in 1: one-cycle hit strobe.
- `hit_idx` in 4: hole index of the hit, valid when `hit_valid`=1.
- `map` out 9: bit i=1 means a mole is up in hole i.
- `score` out 4: round score, saturating at 15.
- `playing` out 1: 1 while in PLAY.
- `game_over` out 1: 1 while in OVER.

## Operation
- FSM has three states:
  - IDLE: after reset.
  - PLAY: entered on `start` from IDLE or OVER.
  - OVER: entered when the remaining-tick count reaches 0 in PLAY.
  - `start` is ignored while in PLAY.
- On entering PLAY:
  - `score`=0, `map`=0, all hole life counters cleared.
  - Cycle divider cleared; remaining=`GAME_TICKS`; spawn counter=`SPAWN_GAP`.
- Tick: the divider counts 0..`TICK_DIV`-1 in PLAY only. `tick` pulses for one cycle at the wrap.
- On each tick:
  - remaining decrements by 1.
  - Every occupied hole's life counter decrements; a counter reaching 0 clears its `map` bit.
  - The spawn counter decrements. When it reaches 0 it reloads `SPAWN_GAP` and a spawn attempt is made.
- Spawn attempt:
  - cand = `lfsr[3:0]`, minus 9 if ≥9 (result 0..8).
  - If `map[cand]`=0: set it and load its life counter with `MOLE_LIFE`.
  - If `map[cand]`=1: no spawn this attempt, no retry.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seeded 16'hACE1 on reset; advances every cycle in all states.
- Hit, processed in PLAY only:
  - If `hit_valid`=1, `hit_idx`≤8 and `map[hit_idx]`=1: clear that bit and increment `score`, saturating at 15.
  - `hit_idx`≥9: ignored.
  - Empty hole: see Configuration.
- Simultaneous events in the same cycle:
  - Hit and expiry on the same hole: the hit wins and scores.
  - Spawn and hit on different holes: both take effect.
  - Spawn decisions use the pre-update `map`.
- When remaining reaches 0 on a tick: go to OVER, force `map`=0, hold `score`. Spawns and expiries in that tick are discarded.
- OVER holds until `start`. A new round clears `score`.

## Timing
- All outputs are registered.
- Reset values: `map`=0, `score`=0, `playing`=0, `game_over`=0; FSM=IDLE, LFSR=16'hACE1, divider=0.
- `start` at cycle N: `playing`=1 and `game_over`=0 at N+1.
- Hit at cycle N: `map`/`score` update at N+1.
- First spawn attempt: tick number `SPAWN_GAP` after `start`. A mole spawned on tick k is cleared on tick k+`MOLE_LIFE`.
- Round end: `playing` falls and `game_over` rises on the cycle after the `GAME_TICKS`-th tick pulse.
- Reset asserted mid-round: every register returns to its reset value immediately (asynchronous), with no wait for a clock edge.

## Configuration
- `MOLE_MISS_PENALTY_EN`:
  - Defined: a valid hit (`hit_idx`≤8) on an empty hole decrements `score`, saturating at 0.
  - Undefined: such hits are ignored and `score` is unchanged.
- Idx≥9 is ignored in both builds.

## Test plan
Bench parameters: `TICK_DIV`=4, `MOLE_LIFE`=3, `SPAWN_GAP`=2, `GAME_TICKS`=10.
- Reset, then `start`:
  - First spawn on tick 2 into hole (0xACE1-derived LFSR state mod-9 rule).
  - That bit clears on tick 5.
  - `game_over`=1 one cycle after tick 10, `map`=0.
- Hit on an occupied hole: bit clears and `score` 0→1 the next cycle. A second hit on the same hole gives no change; with `MOLE_MISS_PENALTY_EN`, `score` 1→0.
- Hit on the mole's expiry tick cycle: `score` increments and `map` bit is 0.
- Force 16 successful hits (backdoor `map`): `score` holds 15.
- `hit_idx`=12 with `hit_valid`: no change in either build. `start` pulsed during PLAY: remaining and `score` unchanged.
- Drive `rst`=0 mid-round: outputs go to 0 asynchronously. After release, `start` replays an identical spawn sequence.
